// File: rtl/hex_keypad_entry.sv
// rtl/hex_keypad_entry.sv - 4x4 hex keypad scanner with debounce and two-digit byte assembly
module hex_keypad_entry #(
    parameter int SCAN_DIV        = 5000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    input  logic       clear,
    input  logic       byte_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [3:0] key_code,
    output logic       key_pressed,
    output logic       key_dropped,
    output logic       digit_count
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    logic [3:0]    col_meta_q;
    logic [3:0]    cs_q;

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cap_pat_q, cap_pat_d;
    logic [1:0]    cap_col_q, cap_col_d;
    logic [1:0]    low_col;
    logic          accept;

    logic [3:0]    row_out_q, row_out_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_pressed_q, key_pressed_d;
    logic          key_dropped_q, key_dropped_d;
    logic [3:0]    hi_nib_q, hi_nib_d;
    logic [7:0]    byte_out_q, byte_out_d;
    logic          byte_valid_q, byte_valid_d;
    logic          digit_count_q, digit_count_d;

    // Idle columns read high, so the synchronizer resets to "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            cs_q       <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            cs_q       <= col_meta_q;
        end
    end

    always_comb begin
        low_col = 2'd0;
        if (!cs_q[0])      low_col = 2'd0;
        else if (!cs_q[1]) low_col = 2'd1;
        else if (!cs_q[2]) low_col = 2'd2;
        else if (!cs_q[3]) low_col = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            row_q     <= 2'd0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            cap_pat_q <= 4'hF;
            cap_col_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            cap_pat_q <= cap_pat_d;
            cap_col_q <= cap_col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        cap_pat_d = cap_pat_q;
        cap_col_d = cap_col_q;
        accept    = 1'b0;
        case (state_q)
            SCAN: begin
                // Sample only at the end of the dwell so the synchronizer has settled on this row.
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (cs_q != 4'hF) begin
                        cap_pat_d = cs_q;
                        cap_col_d = low_col;
                        cnt_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (cs_q != cap_pat_q) begin
                    state_d = SCAN;
                    dwell_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (cs_q != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    dwell_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = SCAN;
                row_d   = 2'd0;
                dwell_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        row_out_d     = ~(4'b0001 << row_d);
        key_code_d    = key_code_q;
        key_pressed_d = accept;
        key_dropped_d = 1'b0;
        hi_nib_d      = hi_nib_q;
        byte_out_d    = byte_out_q;
        byte_valid_d  = byte_valid_q;
        digit_count_d = digit_count_q;

        if (byte_valid_q && byte_ready) begin
            byte_valid_d = 1'b0;
        end

        // Acceptance looks at the pre-edge byte_valid, so a same-cycle ready still drops the key.
        if (accept) begin
            key_code_d = {row_q, cap_col_q};
            if (byte_valid_q) begin
                key_dropped_d = 1'b1;
            end else if (!clear) begin
                if (!digit_count_q) begin
                    hi_nib_d      = {row_q, cap_col_q};
                    digit_count_d = 1'b1;
                end else begin
                    byte_out_d    = {hi_nib_q, row_q, cap_col_q};
                    byte_valid_d  = 1'b1;
                    digit_count_d = 1'b0;
                end
            end
        end

        if (clear) begin
            digit_count_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_out_q     <= 4'b1110;
            key_code_q    <= 4'h0;
            key_pressed_q <= 1'b0;
            key_dropped_q <= 1'b0;
            hi_nib_q      <= 4'h0;
            byte_out_q    <= 8'h00;
            byte_valid_q  <= 1'b0;
            digit_count_q <= 1'b0;
        end else begin
            row_out_q     <= row_out_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
            key_dropped_q <= key_dropped_d;
            hi_nib_q      <= hi_nib_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign row_out     = row_out_q;
    assign key_code    = key_code_q;
    assign key_pressed = key_pressed_q;
    assign key_dropped = key_dropped_q;
    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign digit_count = digit_count_q;

endmodule

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Scans a 4x4 hexadecimal keypad, debounces key presses, and assembles two consecutive hex digits into a byte. Output is a valid/ready handshake to the control logic. It is the input-side counterpart of the binary-to-hex display path: the user enters a value (e.g. a temperature setpoint or device code) digit by digit, and the same byte is later rendered back on the two hex digits of the display.

## Interface
- `SCAN_DIV`, default 5000: clock cycles each row is driven before advancing. Minimum 4.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required for press and for release. Minimum 2.
- `clk`  in  1  system clock; the block uses only this clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `col_in`  in  4  keypad columns, active-low, pulled up externally, asynchronous.
- `row_out`  out  4  keypad row drive, active-low one-hot.
- `clear`  in  1  synchronous; discards a pending first digit.
- `byte_ready`  in  1  consumer accepts `byte_out`.
- `byte_out`  out  8  assembled byte: first digit in [7:4], second digit in [3:0].
- `byte_valid`  out  1  `byte_out` holds an unconsumed byte.
- `key_code`  out  4  code of the last accepted key.
- `key_pressed`  out  1  one-cycle pulse on key acceptance.
- `key_dropped`  out  1  one-cycle pulse when an accepted key is discarded because `byte_valid` is high.
- `digit_count`  out  1  1 = first digit held, waiting for the second.

## Operation
- `col_in` passes through a 2-flop synchronizer. All logic below uses the synchronized value `cs`.
- Key code = row*4 + col, where row and col are indices 0..3. Example: row 2, col 1 -> 4'h9.
- If several columns are low, the lowest-index column is taken.

FSM states: SCAN, DEBOUNCE, RELEASE.
- **SCAN**
  - The row index advances 0->1->2->3->0 every `SCAN_DIV` cycles; `row_out` = ~(1<<row).
  - `cs` is sampled on the last dwell cycle of each row.
  - If `cs` != 4'hF at that sample: capture row and column, freeze the row, go to DEBOUNCE.
- **DEBOUNCE**
  - The counter counts cycles in which `cs` equals the captured pattern.
  - Any mismatch: go to SCAN, starting from the same row with the dwell counter reset.
  - On the `DEBOUNCE_CYCLES`-th consecutive match: accept the key and go to RELEASE.
- **RELEASE**
  - The row stays frozen.
  - The counter counts consecutive cycles with `cs` == 4'hF; any low column restarts the count.
  - On reaching `DEBOUNCE_CYCLES`: go to SCAN at the next row.

Acceptance, in the same cycle:
- `key_code` is updated and `key_pressed` is pulsed.
- If `byte_valid` is high: the key is discarded, `key_dropped` pulses, and `digit_count` is unchanged.
- Else, if `digit_count` = 0: store the code as the high nibble and set `digit_count` = 1.
- Else: `byte_out` = {high nibble, code}, `byte_valid` = 1, `digit_count` = 0.

Other rules:
- **`clear`:** sets `digit_count` = 0 next cycle. It never affects `byte_valid`/`byte_out`, the FSM, or scanning. If `clear` coincides with acceptance, `clear` wins: no nibble is stored and no byte is formed; `key_pressed` still pulses.
- **Handshake:** `byte_valid` falls the cycle after `byte_valid && byte_ready`. `byte_out` is stable while `byte_valid` is high.
- **Ready and second digit in the same cycle:** if `byte_ready` is high in the cycle a second digit is accepted while `byte_valid` is high, the key is still dropped, because acceptance uses the pre-edge `byte_valid`.
- **Reset:** asynchronous reset at any point returns to SCAN at row 0. Reset values:
  - `row_out` = 4'b1110
  - `byte_out` = 8'h00, `byte_valid` = 0
  - `key_code` = 4'h0, `key_pressed` = 0, `key_dropped` = 0
  - `digit_count` = 0
  - counters and synchronizer cleared; synchronizer resets to 4'hF.

## Timing
- All outputs are registered.
- **Press latency:** a column going low at the pin while its row is driven reaches `cs` after 2 cycles. Detection occurs at the end of the dwell.
- **Acceptance:** `key_pressed` is asserted `DEBOUNCE_CYCLES` cycles after entry to DEBOUNCE.
- **Byte formation:** `byte_valid` is high in the cycle after the second `key_pressed` edge, i.e. updated on the same clock edge as `key_pressed` goes high.
- **Scan period:** 4*`SCAN_DIV` cycles.
- **Key rate:** worst case, one key is accepted per 2*`DEBOUNCE_CYCLES` + 4*`SCAN_DIV` + 2 cycles.
- **Held key:** a key held indefinitely produces exactly one acceptance.

## Test plan
Bench settings: `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8. The keypad model pulls the column low only while its row is driven.

1. **Reset values:** hold `rst_n` low mid-scan -> `row_out`=4'b1110, all outputs zero; release -> rows step every 4 cycles: 1110, 1101, 1011, 0111.
2. **Entering 0x3A:** press row0/col3, release, then press row2/col2 (code 0xA), release -> `key_pressed` pulses with `key_code` 3 then A; `digit_count` goes 1 then 0; `byte_out`=8'h3A with `byte_valid`=1; `byte_ready`=1 one cycle -> `byte_valid`=0 next cycle.
3. **Bounce:** toggle col1 low/high every 3 cycles for 30 cycles, then hold low -> no acceptance during bounce; exactly one `key_pressed` with `key_code`=1 after 8 stable cycles; holding 200 cycles yields no repeat.
4. **Overrun:** with byte 8'h12 pending and `byte_ready`=0, press key 0x7 -> `key_pressed` and `key_dropped` both pulse; `byte_out` stays 8'h12; `digit_count` stays 0.
5. **Clear:** press 0x5, then pulse `clear` -> `digit_count`=0; then press 0xC and 0xD -> `byte_out`=8'hCD.
6. **Clear and reset collisions:**
   - Assert `clear` in the acceptance cycle of the first digit -> `digit_count` stays 0.
   - Assert `rst_n` low during RELEASE -> FSM returns to row 0 and no spurious `key_pressed` occurs.
